// File: rtl/target_spawn_scheduler.sv
// Target spawn scheduler: per-channel WAIT/LIVE timers with LFSR jitter,
// an accepted-kill counter and a boss phase (OFF -> ARM -> LIVE -> DONE)
// that takes over once enough kills have been accepted.
module target_spawn_scheduler #(
    parameter int          N_TGT      = 6,
    parameter int          BASE_DELAY = 300000000,
    parameter int          JITTER_W   = 27,
    parameter int          CNT_W      = 30,
    parameter logic [31:0] SEED       = 32'h000000FF,
    parameter int          BOSS_KILLS = 20,
    parameter int          BOSS_HOLD  = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic [N_TGT-1:0] kill,
    input  logic             boss_kill,
    output logic [N_TGT-1:0] spawn,
    output logic [N_TGT-1:0] active,
    output logic             boss_spawn,
    output logic             boss_active,
    output logic             boss_done,
    output logic [7:0]       kill_count
);

    typedef enum logic [1:0] {B_OFF, B_ARM, B_LIVE, B_DONE} boss_e;

    localparam logic [CNT_W-1:0] BASE      = CNT_W'(BASE_DELAY);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(BOSS_HOLD - 1);

    // Jitter for channel sh: LFSR rotated left by sh, low JITTER_W bits.
    function automatic logic [CNT_W-1:0] jitter(input logic [31:0] x, input int sh);
        logic [31:0] r;
        r = (x << sh) | (x >> (32 - sh));
        return CNT_W'(r[JITTER_W-1:0]);
    endfunction

    boss_e                        boss_q;
    logic [31:0]                  lfsr_q, lfsr_d;
    logic [N_TGT-1:0]             live_q, live_d;
    logic [N_TGT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_TGT-1:0][CNT_W-1:0]  dly_q, dly_d;
    logic [CNT_W-1:0]             timer_q;
    logic [7:0]                   kc_q, kc_d;
    logic                         boss_active_q, boss_done_q;
    logic                         run;
    logic [N_TGT-1:0]             accept, spawn_c;
    logic [4:0]                   pop;
    logic [8:0]                   kc_sum;

    // Channels only advance while the game runs unfrozen and no boss phase is in progress.
    assign run = enable & ~freeze & (boss_q == B_OFF);

    // Kill acceptance and spawn decode from the current channel state.
    always_comb begin
        accept  = '0;
        spawn_c = '0;
        for (int i = 0; i < N_TGT; i++) begin
            accept[i]  = enable & ~freeze & live_q[i] & kill[i];
            spawn_c[i] = ~reset & run & ~live_q[i] & (cnt_q[i] == dly_q[i]);
        end
    end

    // Channel next state: accepted kill re-arms with a fresh jittered delay.
    always_comb begin
        live_d = live_q;
        cnt_d  = cnt_q;
        dly_d  = dly_q;
        for (int i = 0; i < N_TGT; i++) begin
            if (!enable) begin
                live_d[i] = 1'b0;
                cnt_d[i]  = '0;
                dly_d[i]  = BASE;
            end else if (accept[i]) begin
                live_d[i] = 1'b0;
                cnt_d[i]  = '0;
                dly_d[i]  = BASE + jitter(lfsr_q, i);
            end else if (spawn_c[i]) begin
                live_d[i] = 1'b1;
                cnt_d[i]  = '0;
            end else if (run && !live_q[i]) begin
                cnt_d[i]  = cnt_q[i] + 1'b1;
            end
        end
    end

    // Saturating kill counter; boss kills are never counted.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_TGT; i++) begin
            pop = pop + 5'(accept[i]);
        end
        kc_sum = 9'(kc_q) + 9'(pop);
        if (!enable) begin
            kc_d = '0;
        end else if (kc_sum > 9'd255) begin
            kc_d = 8'hFF;
        end else begin
            kc_d = kc_sum[7:0];
        end
    end

    // Free-running LFSR, taps 32,22,2,1, self-recovering from the all-zero state.
    always_comb begin
        if (lfsr_q == 32'd0) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end
    end

    // Channel, counter and LFSR registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
            live_q <= '0;
            cnt_q  <= '0;
            dly_q  <= {N_TGT{BASE}};
            kc_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            live_q <= live_d;
            cnt_q  <= cnt_d;
            dly_q  <= dly_d;
            kc_q   <= kc_d;
        end
    end

    // Boss pulse fires on the last cycle of the ARM hold.
    assign boss_spawn = ~reset & enable & ~freeze & (boss_q == B_ARM) & (timer_q == HOLD_LAST);

    // Boss FSM with registered live/done flags; freeze holds everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boss_q        <= B_OFF;
            timer_q       <= '0;
            boss_active_q <= 1'b0;
            boss_done_q   <= 1'b0;
        end else if (!enable) begin
            boss_q        <= B_OFF;
            timer_q       <= '0;
            boss_active_q <= 1'b0;
            boss_done_q   <= 1'b0;
        end else if (!freeze) begin
            case (boss_q)
                B_OFF: begin
                    if (int'(kc_d) >= BOSS_KILLS) begin
                        boss_q  <= B_ARM;
                        timer_q <= '0;
                    end
                end
                B_ARM: begin
                    if (timer_q == HOLD_LAST) begin
                        boss_q        <= B_LIVE;
                        boss_active_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                B_LIVE: begin
                    if (boss_kill) begin
                        boss_q        <= B_DONE;
                        boss_active_q <= 1'b0;
                        boss_done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spawn       = spawn_c;
    assign active      = live_q;
    assign boss_active = boss_active_q;
    assign boss_done   = boss_done_q;
    assign kill_count  = kc_q;

endmodule
